// File: rtl/series_engine_arbiter_if.sv
// ---------------------------------------------------------------------------
// series_engine_arbiter_if
//   Bundles every signal exchanged by the series-engine arbiter with its
//   requesters and with the shared engine. Suffixes are written from the
//   arbiter's point of view: _i is an arbiter input, _o is an arbiter output.
//
//   Requester side
//     req_i        NREQ     level request, held until done/err
//     req_x_i      NREQ*DW  operand x, slice i = req_x_i[i*DW +: DW]
//     req_y_i      NREQ*DW  operand y, same packing
//     grant_o      NREQ     one-hot owner of the engine, 0 when idle
//     done_o       NREQ     one-cycle completion pulse to the owner
//     err_o        NREQ     one-cycle timeout-abort pulse to the owner
//     result_o     DW       last captured engine result
//     busy_o       1        a job is in flight
//   Engine side
//     eng_start_o  1        start pulse
//     eng_x_o      DW       latched operand x
//     eng_y_o      DW       latched operand y
//     eng_ready_i  1        engine is idle (level)
//     eng_result_i DW       engine answer, valid when eng_ready_i after a run
//     eng_rst_o    1        active-high engine reset, pulsed on abort
//
//   Modports: slave = the arbiter, master = whatever drives the requests
//   and models the engine.
// ---------------------------------------------------------------------------
interface series_engine_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ*DW-1:0] req_x_i;
    logic [NREQ*DW-1:0] req_y_i;
    logic [NREQ-1:0]    grant_o;
    logic [NREQ-1:0]    done_o;
    logic [NREQ-1:0]    err_o;
    logic [DW-1:0]      result_o;
    logic               busy_o;
    logic               eng_start_o;
    logic [DW-1:0]      eng_x_o;
    logic [DW-1:0]      eng_y_o;
    logic               eng_ready_i;
    logic [DW-1:0]      eng_result_i;
    logic               eng_rst_o;

    modport slave (
        input  req_i, req_x_i, req_y_i, eng_ready_i, eng_result_i,
        output grant_o, done_o, err_o, result_o, busy_o,
               eng_start_o, eng_x_o, eng_y_o, eng_rst_o
    );

    modport master (
        output req_i, req_x_i, req_y_i, eng_ready_i, eng_result_i,
        input  grant_o, done_o, err_o, result_o, busy_o,
               eng_start_o, eng_x_o, eng_y_o, eng_rst_o
    );
endinterface

// File: rtl/series_engine_arbiter.sv
// ---------------------------------------------------------------------------
// series_engine_arbiter
//   Shares one series-evaluation engine among NREQ requesters. A round-robin
//   pick is made in IDLE whenever the engine reports ready; the winner's
//   operands are latched, the engine is started with a single-cycle pulse,
//   and the job is followed until the engine returns to ready (done pulse,
//   result captured) or the timeout expires (err pulse plus engine reset).
//
//   Parameters
//     NREQ   number of requesters (2..8)
//     DW     operand/result width
//     TMO_W  timeout counter width; a job aborts after 2**TMO_W-1 cycles
//            in RUN without the engine returning to ready
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; a job in flight is dropped
//            silently (no done/err pulse)
//     bus    series_engine_arbiter_if.slave, see the interface header
// ---------------------------------------------------------------------------
module series_engine_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int TMO_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    series_engine_arbiter_if.slave   bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [IW-1:0]      owner_q,  owner_d;
    logic [NREQ-1:0]    grant_q,  grant_d;
    logic [IW-1:0]      ptr_q,    ptr_d;
    logic [TMO_W-1:0]   tmo_q,    tmo_d;
    logic [DW-1:0]      result_q, result_d;
    logic [DW-1:0]      x_q,      x_d;
    logic [DW-1:0]      y_q,      y_d;
    logic               start_q,  start_d;

    // -----------------------------------------------------------------------
    // Operand slices and round-robin candidate list
    // -----------------------------------------------------------------------
    logic [DW-1:0]      x_slice  [NREQ];
    logic [DW-1:0]      y_slice  [NREQ];
    logic [IW:0]        cand_sum [NREQ];
    logic [IW-1:0]      cand_idx [NREQ];
    logic [NREQ-1:0]    cand_req;
    logic [IW-1:0]      win_idx;
    logic [NREQ-1:0]    win_onehot;
    logic               win_found;
    logic [IW-1:0]      next_ptr;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign x_slice[gi] = bus.req_x_i[gi*DW +: DW];
            assign y_slice[gi] = bus.req_y_i[gi*DW +: DW];
        end
    endgenerate

    // Candidate k is the requester k positions after the pointer, wrapping
    // at NREQ. One extra bit on the sum keeps ptr+k from overflowing before
    // the wrap is applied.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_q} + (IW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IW+1)'(NREQ))
                                ? IW'(cand_sum[gi] - (IW+1)'(NREQ))
                                : IW'(cand_sum[gi]);
            assign cand_req[gi] = bus.req_i[cand_idx[gi]];
        end
    endgenerate

    // Scanning from the far end down to offset 0 lets the nearest requester
    // at/after the pointer overwrite any farther one.
    always_comb begin
        win_idx = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    assign win_found = |bus.req_i;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IW'(gi));
        end
    endgenerate

    assign next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        x_d      = x_q;
        y_d      = y_q;
        start_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A not-ready engine in IDLE is still busy (or unknown):
                // hold off granting until it reports idle.
                if (win_found && bus.eng_ready_i) begin
                    grant_d = win_onehot;
                    owner_d = win_idx;
                    x_d     = x_slice[win_idx];
                    y_d     = y_slice[win_idx];
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // start is registered, so it appears the cycle after grant
                // and lasts exactly one cycle.
                start_d = 1'b1;
                state_d = S_RELEASE;
            end

            S_RELEASE: begin
                // Wait for the engine to leave idle; a dead engine that never
                // acknowledges the start is caught by the same timeout.
                tmo_d = tmo_q + TMO_W'(1);
                if (!bus.eng_ready_i) begin
                    tmo_d   = '0;
                    state_d = S_RUN;
                end else if (tmo_d == TMO_MAX) begin
                    state_d = S_ABORT;
                end
            end

            S_RUN: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.eng_ready_i) begin
                    result_d = bus.eng_result_i;
                    state_d  = S_DONE;
                end else if (tmo_d == TMO_MAX) begin
                    state_d = S_ABORT;
                end
            end

            S_DONE: begin
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = S_IDLE;
            end

            S_ABORT: begin
                // result_q is deliberately left untouched on abort.
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = S_IDLE;
            end

            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            tmo_q    <= '0;
            result_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
            x_q      <= x_d;
            y_q      <= y_d;
            start_q  <= start_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // grant_q is still the owner during DONE/ABORT, so masking it by state
    // yields single-bit pulses that can never overlap.
    assign bus.grant_o     = grant_q;
    assign bus.done_o      = (state_q == S_DONE)  ? grant_q : '0;
    assign bus.err_o       = (state_q == S_ABORT) ? grant_q : '0;
    assign bus.result_o    = result_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.eng_start_o = start_q;
    assign bus.eng_x_o     = x_q;
    assign bus.eng_y_o     = y_q;
    assign bus.eng_rst_o   = (state_q == S_ABORT);

endmodule

// File: tb/tb_series_engine_arbiter.sv
module tb_series_engine_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int TMO_W = 8;

    logic clk;
    logic rst_n;

    series_engine_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    series_engine_arbiter #(.NREQ(NREQ), .DW(DW), .TMO_W(TMO_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // ---------------------------------------------------------------
    // Engine model: leaves ready the cycle after start, answers
    // x*y+27 about 20 cycles later; hang_mode makes a job never finish.
    // eng_hold forces ready low to emulate an engine busy elsewhere.
    // ---------------------------------------------------------------
    logic          eng_rdy_q;
    logic [DW-1:0] eng_res_q;
    int            eng_cnt;
    logic          hang_job;
    logic          hang_mode;
    logic          eng_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_rdy_q <= 1'b1;
            eng_res_q <= '0;
            eng_cnt   <= 0;
            hang_job  <= 1'b0;
        end else if (bus.eng_rst_o) begin
            eng_rdy_q <= 1'b1;
            hang_job  <= 1'b0;
        end else if (bus.eng_start_o && eng_rdy_q) begin
            eng_rdy_q <= 1'b0;
            eng_cnt   <= 19;
            hang_job  <= hang_mode;
        end else if (!eng_rdy_q && !hang_job) begin
            if (eng_cnt == 0) begin
                eng_rdy_q <= 1'b1;
                eng_res_q <= bus.eng_x_o * bus.eng_y_o + 16'd27;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    assign bus.eng_ready_i  = eng_rdy_q & ~eng_hold;
    assign bus.eng_result_i = eng_res_q;

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    typedef struct packed {
        logic          is_err;
        logic [1:0]    idx;
        logic [DW-1:0] res;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input logic is_err, input int idx, input logic [DW-1:0] res);
        exp_t e;
        e.is_err = is_err;
        e.idx    = 2'(idx);
        e.res    = res;
        exp_q.push_back(e);
    endtask

    logic prev_start;

    always @(negedge clk) begin
        prev_start <= bus.eng_start_o;
        if (rst_n) begin
            if (prev_start && bus.eng_start_o)
                check("start_pulse_len", {31'd0, bus.eng_start_o & prev_start}, 32'd0);
            if (bus.eng_rst_o || (|bus.err_o))
                check("eng_rst_vs_err", {31'd0, bus.eng_rst_o}, {31'd0, |bus.err_o});
            if ((|bus.done_o) || (|bus.err_o)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {24'd0, bus.done_o, bus.err_o}, 32'd0);
                end else begin
                    exp_t e;
                    logic [NREQ-1:0] oh;
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e.idx;
                    check("pulse_vec", {24'd0, bus.done_o, bus.err_o},
                          {24'd0, (e.is_err ? 4'b0000 : oh), (e.is_err ? oh : 4'b0000)});
                    check("result", {16'd0, bus.result_o}, {16'd0, e.res});
                    check("grant_owner", {28'd0, bus.grant_o}, {28'd0, oh});
                    $display("job owner=%0d kind=%s result=%0d (want owner=%0d result=%0d)",
                             $clog2({28'd0, bus.done_o | bus.err_o}),
                             (|bus.err_o) ? "err" : "done", bus.result_o, e.idx, e.res);
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic set_ops(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
        bus.req_x_i[i*DW +: DW] = x;
        bus.req_y_i[i*DW +: DW] = y;
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((|bus.done_o) || (|bus.err_o)) && n < budget);
        if (!((|bus.done_o) || (|bus.err_o)))
            check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        hang_mode = 1'b0;
        eng_hold  = 1'b0;
        bus.req_i = '0;
        bus.req_x_i = '0;
        bus.req_y_i = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 1), 16'(10 * (i + 1)));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant",  {28'd0, bus.grant_o}, 32'd0);
        check("rst_busy",   {31'd0, bus.busy_o}, 32'd0);
        check("rst_result", {16'd0, bus.result_o}, 32'd0);
        check("rst_eng_x",  {16'd0, bus.eng_x_o}, 32'd0);
        check("rst_start",  {31'd0, bus.eng_start_o}, 32'd0);
        check("rst_eng_rst",{31'd0, bus.eng_rst_o}, 32'd0);
        rst_n = 1'b1;

        // All four requesting: 0,1,2,3 then 0 again
        push(0, 0, 16'd37); push(0, 1, 16'd67); push(0, 2, 16'd117);
        push(0, 3, 16'd187); push(0, 0, 16'd37);
        bus.req_i = 4'b1111;
        for (int j = 0; j < 5; j++) wait_pulse("rr_all", 200);
        bus.req_i = '0;
        @(negedge clk);

        // Single requester 0, x=3 y=5 -> 42; start one cycle after grant
        set_ops(0, 16'd3, 16'd5);
        push(0, 0, 16'd42);
        bus.req_i = 4'b0001;
        @(negedge clk);
        check("t1_grant", {28'd0, bus.grant_o}, 32'd1);
        check("t1_start_at_grant", {31'd0, bus.eng_start_o}, 32'd0);
        @(negedge clk);
        check("t1_start_pulse", {31'd0, bus.eng_start_o}, 32'd1);
        check("t1_eng_x", {16'd0, bus.eng_x_o}, 32'd3);
        @(negedge clk);
        check("t1_start_low", {31'd0, bus.eng_start_o}, 32'd0);
        n = 0;
        while (!bus.eng_ready_i && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        check("t1_done_latency", {28'd0, bus.done_o}, 32'd1);
        bus.req_i = '0;
        @(negedge clk);
        check("t1_grant_clear", {28'd0, bus.grant_o}, 32'd0);
        check("t1_idle", {31'd0, bus.busy_o}, 32'd0);
        set_ops(0, 16'd1, 16'd10);

        // Job on 2, then 0101: pointer at 3 wraps to 0, then 2
        push(0, 2, 16'd117);
        bus.req_i = 4'b0100;
        wait_pulse("t3_a", 200);
        bus.req_i = '0;
        @(negedge clk);
        push(0, 0, 16'd37); push(0, 2, 16'd117);
        bus.req_i = 4'b0101;
        wait_pulse("t3_b", 200);
        wait_pulse("t3_c", 200);
        bus.req_i = '0;
        @(negedge clk);

        // Hung engine: err to owner 1 after 2 + 255 cycles from start
        hang_mode = 1'b1;
        push(1, 1, 16'd117);
        bus.req_i = 4'b0110;
        n = 0;
        while (!bus.eng_start_o && n < 20) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(|bus.err_o) && n < 400);
        check("t4_abort_latency", n, 32'd257);
        hang_mode = 1'b0;
        push(0, 2, 16'd117);
        bus.req_i = 4'b0100;
        wait_pulse("t4_next", 200);
        bus.req_i = '0;
        @(negedge clk);

        // Engine not ready in IDLE: no grant; request dropped before grant
        eng_hold = 1'b1;
        bus.req_i = 4'b0100;
        repeat (4) @(negedge clk);
        check("hold_no_grant", {28'd0, bus.grant_o}, 32'd0);
        bus.req_i = '0;
        @(negedge clk);
        eng_hold = 1'b0;
        repeat (6) @(negedge clk);
        check("dropped_no_grant", {28'd0, bus.grant_o}, 32'd0);
        check("dropped_idle", {31'd0, bus.busy_o}, 32'd0);
        push(0, 0, 16'd37);
        bus.req_i = 4'b0001;
        wait_pulse("hold_after", 200);
        bus.req_i = '0;
        @(negedge clk);

        // Reset mid-RUN drops the job; afterwards pointer restarts at 0
        bus.req_i = 4'b1000;
        n = 0;
        while (bus.eng_ready_i && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("t5_busy", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_grant",  {28'd0, bus.grant_o}, 32'd0);
        check("t5_busy0",  {31'd0, bus.busy_o}, 32'd0);
        check("t5_eng_x",  {16'd0, bus.eng_x_o}, 32'd0);
        check("t5_result", {16'd0, bus.result_o}, 32'd0);
        check("t5_pulses", {24'd0, bus.done_o, bus.err_o}, 32'd0);
        bus.req_i = 4'b1001;
        push(0, 0, 16'd37); push(0, 3, 16'd187);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pulse("t5_a", 200);
        wait_pulse("t5_b", 200);
        bus.req_i = '0;
        @(negedge clk);

        // Operands latched at grant; requester drops mid-RUN, still done
        push(0, 1, 16'd67);
        bus.req_i = 4'b0010;
        n = 0;
        while (bus.grant_o == '0 && n < 20) begin @(negedge clk); n++; end
        set_ops(1, 16'd99, 16'd20);
        n = 0;
        while (bus.eng_ready_i && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        bus.req_i = '0;
        check("t6_eng_x_held", {16'd0, bus.eng_x_o}, 32'd2);
        check("t6_grant_held", {28'd0, bus.grant_o}, 32'd2);
        wait_pulse("t6_done", 200);
        set_ops(1, 16'd2, 16'd20);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
